drawing_rect_fill: RTL
======================

# drawing_rect_fill

Parametrised rectangle fill/outline engine for the 8bpp frame buffer (four pixels per 32-bit word, pixel offset 0 in bits 31:24). It sits in the drawing-engine slot: it takes commands from the processor through the `req`/`ack` register interface and writes the frame buffer through the `de_*` memory bus. It adds colour, outline mode, right/bottom clipping and a configurable frame-buffer geometry, and optionally supports XOR read-modify-write.

## Interface
- `FB_BASE`, default 18'h00000: word address of pixel (0,0).
- `ROW_WORDS`, default 160: words per scan line; clip width is ROW_WORDS*4 pixels.
- `ROWS`, default 480: scan lines; rows with y ≥ ROWS are clipped.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req` in 1: command request, level.
- `ack` out 1: one-cycle pulse when the command is accepted.
- `busy` out 1: high while a command is in progress.
- `r0`..`r7` in 16 each:
  - r0 = x
  - r1 = y
  - r2 = width
  - r3 = height
  - r4[7:0] = colour
  - r5[0] = outline (1) / fill (0)
  - r5[1] = XOR
  - r6 and r7 are ignored.
- `de_req` out 1: memory request, held until `de_ack`.
- `de_ack` in 1: memory transaction complete.
- `de_addr` out 18: word address.
- `de_nbyte` out 4: active-low byte enables; bit 3 is offset 0.
- `de_rnw` out 1: 1 = read, 0 = write.
- `de_w_data` out 32: write data.
- `de_r_data` in 32: read data, valid in the `de_ack` cycle of a read.

## Operation
- States: IDLE → ACK → SETUP → XFER ⇄ NEXT → DONE → IDLE. With XOR enabled, XFER is split into RD → WR.
- **IDLE:** `req` is sampled. When it is high, r0–r5 are latched into internal registers.
- **ACK:** one cycle; `ack` = 1.
- **SETUP:** computes the clipped extents.
  - xe = min(x+w, ROW_WORDS*4), computed in 17 bits.
  - ye = min(y+h, ROWS), computed in 17 bits.
  - If w = 0, h = 0, x ≥ ROW_WORDS*4 or y ≥ ROWS, go directly to DONE.
- **Traversal:** row-major from row y to row ye−1; within a row, word (x>>2) to word ((xe−1)>>2).
  - de_addr = FB_BASE + row*ROW_WORDS + word, truncated to 18 bits.
  - de_w_data = {4{colour}}.
  - de_nbyte bit for offset k is 0 only when the pixel at word*4+k is inside [x, xe) and, in outline mode, is drawn.
- **Outline mode:**
  - The first and last rows are drawn fully.
  - Intermediate rows draw only pixel x and pixel x+w−1; the right edge is drawn only if unclipped.
  - Words in which every byte enable is 1 are skipped: no bus cycle is issued for them.
- **XFER:** `de_req` = 1 with address, data and enables stable until the edge on which `de_ack` = 1.
- **NEXT:** one cycle to advance the word/row. Go to DONE after the last word.
- **DONE:** one cycle; `busy` = 0. `req` is not sampled in this state.
- **Reset:** `rst_n` low at any edge forces IDLE. A request in flight is abandoned with no further bus activity.

## Timing
- Reset values:
  - `ack` = 0, `busy` = 0, `de_req` = 0
  - `de_rnw` = 1, `de_nbyte` = 4'b1111, `de_addr` = 0, `de_w_data` = 0
- `req` high at edge E0 (in IDLE):
  - `ack` is high for cycle E0–E1.
  - `busy` rises at E0.
  - The first `de_req` is asserted from E2.
- A bus transaction ends on the edge where `de_ack` is high. `de_req` is low for exactly one cycle (NEXT) before the next request.
- `de_req` is low whenever `busy` is low; outside XFER, `de_nbyte` = 4'b1111.
- `busy` falls on the edge entering DONE, i.e. the edge that completes the final `de_ack`, or at the end of SETUP for an empty command.
- All arithmetic is unsigned. Row index and word counters are 16 bits. Address overflow wraps modulo 2^18.

## Configuration
- Macro: `DRAW_RECT_XOR_EN`.
- **When defined:** when r5[1] = 1, each word is transferred as:
  - RD: `de_rnw` = 1, `de_nbyte` = 4'b0000.
  - WR: `de_w_data` = `de_r_data` ^ {4{colour}}, with the byte enables given by the normal mask.
  - Skipped words are not read.
- **When undefined:** r5[1] is ignored, no read cycles are ever issued, and `de_rnw` = 0 in every XFER.

## Test plan
- **Fill:** x=5, y=2, w=6, h=1, colour 8'hA5.
  - Exactly two writes: addr 321 with nbyte 4'b1000, then addr 322 with nbyte 4'b0001.
  - Data 32'hA5A5A5A5 for both; `ack` pulses once.
- **Outline:** x=0, y=0, w=12, h=3, r5=1. Exactly seven writes:
  - addr 0, 1, 2 with nbyte 0000
  - addr 160 with nbyte 0111; addr 162 with nbyte 1110
  - addr 320, 321, 322 with nbyte 0000
- **Empty:** w=0 → `ack` pulse, no `de_req`, `busy` back low 2 cycles after `ack`.
- **Clip:** x=636, w=8, y=479, h=4 → one write only: addr 479*160+159 = 76799, nbyte 0000.
- **XOR and stall** (macro defined): r5=2, colour 8'hFF, x=0, y=0, w=4, h=1.
  - `de_ack` is held low for 5 cycles during each phase; all `de_*` outputs must stay stable throughout.
  - Read addr 0 returns 32'h12345678 → write addr 0 with data 32'hEDCBA987, nbyte 0000.
- **Reset mid-operation:** drive `rst_n` low while `de_req` is high on the second word → at the next edge `de_req` = 0 and `busy` = 0, and no further requests follow.

Source files
------------

// File: rtl/drawing_rect_fill_if.sv
// drawing_rect_fill_if: command register interface and frame-buffer memory bus
// of the rectangle fill engine. The engine uses the master modport; the
// processor/memory side uses the slave modport.
interface drawing_rect_fill_if;
  logic        req;
  logic        ack;
  logic        busy;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic        de_req;
  logic        de_ack;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic        de_rnw;
  logic [31:0] de_w_data;
  logic [31:0] de_r_data;

  modport master (
    input  req, r0, r1, r2, r3, r4, r5, r6, r7, de_ack, de_r_data,
    output ack, busy, de_req, de_addr, de_nbyte, de_rnw, de_w_data
  );

  modport slave (
    output req, r0, r1, r2, r3, r4, r5, r6, r7, de_ack, de_r_data,
    input  ack, busy, de_req, de_addr, de_nbyte, de_rnw, de_w_data
  );
endinterface

// File: rtl/drawing_rect_fill.sv
// drawing_rect_fill: rectangle fill/outline engine for the 8bpp frame buffer
// (four pixels per word, pixel offset 0 in bits 31:24, nbyte bit 3).
// Optional XOR read-modify-write is enabled by defining DRAW_RECT_XOR_EN.
module drawing_rect_fill #(
  parameter logic [17:0] FB_BASE   = 18'h00000,
  parameter int unsigned ROW_WORDS = 160,
  parameter int unsigned ROWS      = 480
) (
  input logic               clk,
  input logic               rst_n,
  drawing_rect_fill_if.master bus
);

  localparam logic [16:0] CLIP_W = 17'(ROW_WORDS * 4);
  localparam logic [16:0] CLIP_H = 17'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_SETUP, S_RD, S_XFER, S_NEXT, S_DONE
  } state_t;

  state_t      state;
  logic [15:0] x_q, y_q, w_q, h_q;
  logic [7:0]  colour_q;
  logic        outline_q;
  logic [15:0] row_q, word_q;
  logic        rd_first;

`ifdef DRAW_RECT_XOR_EN
  logic        xor_q;
  assign rd_first = xor_q;
  logic        unused_bits;
  assign unused_bits = ^{bus.r4[15:8], bus.r5[15:2], bus.r6, bus.r7};
`else
  assign rd_first = 1'b0;
  logic        unused_bits;
  assign unused_bits = ^{bus.r4[15:8], bus.r5[15:1], bus.r6, bus.r7};
`endif

  logic [16:0] sum_x, sum_y, xe, ye, xr, last_row;
  logic [15:0] wl, wr, xr_word;
  logic        empty, right_vis, full_row;
  logic [3:0]  mask_n;
  logic [17:0] pix;
  logic        in_span, hit;
  logic [15:0] nxt_row, nxt_word;
  logic        nxt_valid;
  logic [17:0] addr_n;

  // Clipped extents, byte-enable mask of the current word and next word to visit
  always_comb begin
    sum_x     = {1'b0, x_q} + {1'b0, w_q};
    sum_y     = {1'b0, y_q} + {1'b0, h_q};
    xe        = (sum_x < CLIP_W) ? sum_x : CLIP_W;
    ye        = (sum_y < CLIP_H) ? sum_y : CLIP_H;
    empty     = (w_q == '0) || (h_q == '0) ||
                ({1'b0, x_q} >= CLIP_W) || ({1'b0, y_q} >= CLIP_H);
    wl        = {2'b00, x_q[15:2]};
    wr        = 16'((xe - 17'd1) >> 2);
    xr        = sum_x - 17'd1;
    xr_word   = 16'(xr >> 2);
    right_vis = (sum_x <= CLIP_W);
    last_row  = sum_y - 17'd1;
    // The bottom edge is the true last row; when clipped it is not drawn
    full_row  = !outline_q || (row_q == y_q) || ({1'b0, row_q} == last_row);

    pix     = '0;
    in_span = 1'b0;
    hit     = 1'b0;
    mask_n  = '1;
    for (int unsigned k = 0; k < 4; k++) begin
      pix     = {word_q, 2'(k)};
      in_span = (pix >= {2'b00, x_q}) && (pix < {1'b0, xe});
      hit     = full_row || (pix == {2'b00, x_q}) ||
                (right_vis && (pix == {1'b0, xr}));
      mask_n[3-k] = !(in_span && hit);
    end

    // Intermediate outline rows jump straight from the left-edge word to the
    // right-edge word, so all-disabled words never reach the bus
    nxt_row   = row_q + 16'd1;
    nxt_word  = wl;
    nxt_valid = (({1'b0, row_q} + 17'd1) < ye);
    if (full_row) begin
      if (word_q < wr) begin
        nxt_row   = row_q;
        nxt_word  = word_q + 16'd1;
        nxt_valid = 1'b1;
      end
    end else if ((word_q == wl) && right_vis && (xr_word != wl)) begin
      nxt_row   = row_q;
      nxt_word  = xr_word;
      nxt_valid = 1'b1;
    end

    addr_n = FB_BASE + 18'(32'(row_q) * ROW_WORDS) + 18'(word_q);
  end

  // Command sequencer with registered handshake and memory-bus outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.ack       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.de_req    <= 1'b0;
      bus.de_rnw    <= 1'b1;
      bus.de_nbyte  <= '1;
      bus.de_addr   <= '0;
      bus.de_w_data <= '0;
      x_q           <= '0;
      y_q           <= '0;
      w_q           <= '0;
      h_q           <= '0;
      colour_q      <= '0;
      outline_q     <= 1'b0;
      row_q         <= '0;
      word_q        <= '0;
`ifdef DRAW_RECT_XOR_EN
      xor_q         <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            x_q       <= bus.r0;
            y_q       <= bus.r1;
            w_q       <= bus.r2;
            h_q       <= bus.r3;
            colour_q  <= bus.r4[7:0];
            outline_q <= bus.r5[0];
`ifdef DRAW_RECT_XOR_EN
            xor_q     <= bus.r5[1];
`endif
            row_q     <= bus.r1;
            word_q    <= {2'b00, bus.r0[15:2]};
            bus.ack   <= 1'b1;
            bus.busy  <= 1'b1;
            state     <= S_ACK;
          end
        end
        S_ACK: begin
          bus.ack <= 1'b0;
          state   <= S_SETUP;
        end
        S_SETUP, S_NEXT: begin
          if ((state == S_SETUP) && empty) begin
            bus.busy <= 1'b0;
            state    <= S_DONE;
          end else begin
            bus.de_req    <= 1'b1;
            bus.de_addr   <= addr_n;
            bus.de_w_data <= {4{colour_q}};
            if (rd_first) begin
              bus.de_rnw   <= 1'b1;
              bus.de_nbyte <= '0;
              state        <= S_RD;
            end else begin
              bus.de_rnw   <= 1'b0;
              bus.de_nbyte <= mask_n;
              state        <= S_XFER;
            end
          end
        end
        S_RD: begin
          // Request stays asserted; the write phase follows the read directly
          if (bus.de_ack) begin
            bus.de_rnw    <= 1'b0;
            bus.de_nbyte  <= mask_n;
            bus.de_w_data <= bus.de_r_data ^ {4{colour_q}};
            state         <= S_XFER;
          end
        end
        S_XFER: begin
          if (bus.de_ack) begin
            bus.de_req   <= 1'b0;
            bus.de_rnw   <= 1'b1;
            bus.de_nbyte <= '1;
            if (nxt_valid) begin
              row_q  <= nxt_row;
              word_q <= nxt_word;
              state  <= S_NEXT;
            end else begin
              bus.busy <= 1'b0;
              state    <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
